// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: each stage adds one CW-bit chunk and hands its
// carry to the next stage; valid/ready handshake with a single global stall.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW  = (STAGES == 0) ? WIDTH : WIDTH / STAGES;
  localparam int unsigned TOP = WIDTH - CW;

  if (STAGES < 1) begin : g_bad_stages
    $error("pipelined_addsub: STAGES must be at least 1");
  end else if ((WIDTH % STAGES) != 0) begin : g_bad_split
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
  end

  logic              adv;
  logic [WIDTH-1:0]  b_eff;
  logic              c0;

  // Per-stage combinational inputs (stage 0 fed from the operand ports)
  logic [WIDTH-1:0]  st_a   [STAGES];
  logic [WIDTH-1:0]  st_b   [STAGES];
  logic [WIDTH-1:0]  st_res [STAGES];
  logic [STAGES-1:0] st_c;
  logic [STAGES-1:0] st_v;
  logic [CW:0]       chunk  [STAGES];
  logic [STAGES-1:0] chunk_ovf;

  // Stage registers
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] cy_q;
  logic [STAGES-1:0] ov_q;
  logic [WIDTH-1:0]  a_q    [STAGES];
  logic [WIDTH-1:0]  b_q    [STAGES];
  logic [WIDTH-1:0]  res_q  [STAGES];

  // The whole pipe moves only when the output slot is free or being drained
  assign adv      = out_ready | ~vld_q[STAGES-1];
  assign in_ready = adv;

  // Operand preparation: subtraction is A + ~B + 1
  always_comb begin
    b_eff = sub ? ~inb : inb;
    c0    = sub ? 1'b1 : cin;
  end

  // Remaining operand chunks sit at the bottom of st_a/st_b; finished result
  // chunks enter res from the top so that chunk 0 lands at bit 0 at the end.
  always_comb begin
    st_a[0]   = ina;
    st_b[0]   = b_eff;
    st_res[0] = '0;
    st_c[0]   = c0;
    st_v[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k]   = a_q[k-1];
      st_b[k]   = b_q[k-1];
      st_res[k] = res_q[k-1];
      st_c[k]   = cy_q[k-1];
      st_v[k]   = vld_q[k-1];
    end
  end

  // Chunk adders; the overflow term is only meaningful in the final stage,
  // where the chunk top bits are the operand and result MSBs.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      chunk[k] = (CW+1)'(st_a[k][CW-1:0]) + (CW+1)'(st_b[k][CW-1:0])
               + (CW+1)'(st_c[k]);
      chunk_ovf[k] = (st_a[k][CW-1] == st_b[k][CW-1])
                   & (chunk[k][CW-1] != st_a[k][CW-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cy_q  <= '0;
      ov_q  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= st_v[k];
        cy_q[k]  <= chunk[k][CW];
        ov_q[k]  <= chunk_ovf[k];
        a_q[k]   <= st_a[k] >> CW;
        b_q[k]   <= st_b[k] >> CW;
        res_q[k] <= (st_res[k] >> CW) | (WIDTH'(chunk[k][CW-1:0]) << TOP);
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = res_q[STAGES-1];
  assign cout      = cy_q[STAGES-1];
  assign ovf       = ov_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed corner cases, random traffic with
// random backpressure, and an asynchronous reset while transactions are in flight.
module tb_pipelined_addsub;

  localparam int unsigned W      = 16;
  localparam int unsigned STAGES = 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] ina       = '0;
  logic [W-1:0] inb       = '0;
  logic         cin       = 1'b0;
  logic         sub       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   n_popped = 0;
  bit   rnd_rdy  = 1'b0;
  bit   fixed_rdy = 1'b1;
  exp_t q[$];

  pipelined_addsub #(.WIDTH(W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ina       (ina),
    .inb       (inb),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic, no chunking
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s);
    exp_t r;
    int   sa;
    int   sb;
    int   t;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      t   = sa - sb;
      r.c = (a >= b);
    end else begin
      t   = sa + sb + int'(c);
      r.c = ((32'(a) + 32'(b) + 32'(c)) > 32'h0000_FFFF);
    end
    r.s = t[W-1:0];
    r.v = (t > 32767) || (t < -32768);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  // out_ready is owned by this process; +2 keeps it clear of input driving
  initial forever begin
    @(posedge clk);
    #2;
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
  end

  // Compare process: scoreboard, handshake rule, stall stability
  initial begin : monitor
    bit           prev_stall;
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic         prev_ovf;
    exp_t         e;
    prev_stall = 1'b0;
    prev_sum   = '0;
    prev_cout  = 1'b0;
    prev_ovf   = 1'b0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        prev_stall = 1'b0;
      end else begin
        chk("mon_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
        if (prev_stall) begin
          chk("stall_valid", 32'(out_valid), 32'h1);
          chk("stall_sum",   32'(sum),       32'(prev_sum));
          chk("stall_cout",  32'(cout),      32'(prev_cout));
          chk("stall_ovf",   32'(ovf),       32'(prev_ovf));
        end
        if (out_valid) begin
          chk("mon_expected_result", 32'(q.size() != 0), 32'h1);
          if (q.size() != 0) begin
            e = q[0];
            chk("mon_sum",  32'(sum),  32'(e.s));
            chk("mon_cout", 32'(cout), 32'(e.c));
            chk("mon_ovf",  32'(ovf),  32'(e.v));
            if (out_ready) begin
              void'(q.pop_front());
              n_popped++;
            end
          end
        end
        if (in_valid && in_ready) q.push_back(model(ina, inb, cin, sub));
        prev_stall = out_valid && !out_ready;
        prev_sum   = sum;
        prev_cout  = cout;
        prev_ovf   = ovf;
      end
    end
  end

  // Present one operand set from posedge+1 until accepted
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic s);
    bit ok;
    bit r;
    ina = a; inb = b; cin = c; sub = s; in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      ok = r;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'h0, 32'h1);
  endtask

  // Directed transaction with out_ready held high; latency counts the accept edge
  task automatic one(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic c, input logic s,
                     input logic [W-1:0] es, input logic ec, input logic ev);
    int lat;
    send(a, b, c, s);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(STAGES));
    chk({nm, "_sum"},  32'(sum),  32'(es));
    chk({nm, "_cout"}, 32'(cout), 32'(ec));
    chk({nm, "_ovf"},  32'(ovf),  32'(ev));
    @(posedge clk);
    #1;
    chk({nm, "_single_cycle"}, 32'(out_valid), 32'h0);
  endtask

  initial begin : main
    exp_t e;
    int   base;
    int   seen;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_sum",       32'(sum),       32'h0);
    chk("rst_cout",      32'(cout),      32'h0);
    chk("rst_ovf",       32'(ovf),       32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // Pin the reference model to hand-computed values
    e = model(16'h00FF, 16'h0001, 1'b0, 1'b0);
    chk("model_add", 32'(e), 32'({16'h0100, 1'b0, 1'b0}));
    e = model(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("model_add_ovf", 32'(e), 32'({16'h8000, 1'b0, 1'b1}));
    e = model(16'h8000, 16'h0001, 1'b1, 1'b1);
    chk("model_sub_ovf", 32'(e), 32'({16'h7FFF, 1'b1, 1'b1}));
    e = model(16'h0003, 16'h0005, 1'b0, 1'b1);
    chk("model_sub_borrow", 32'(e), 32'({16'hFFFE, 1'b0, 1'b0}));

    // Directed cases
    @(posedge clk);
    #1;
    one("add_basic",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    one("add_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    one("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    one("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    one("sub_borrow", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    one("sub_b_zero", 16'h1234, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0);

    // 8 back-to-back random transactions under random backpressure
    rnd_rdy = 1'b1;
    base = n_popped;
    for (int i = 0; i < 8; i++)
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int n = 0; n < 1000 && q.size() != 0; n++) @(posedge clk);
    #1;
    chk("bp_drained", 32'(q.size()), 32'h0);
    chk("bp_count",   32'(n_popped - base), 32'd8);

    // Longer random traffic with idle gaps
    base = n_popped;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 2000 && q.size() != 0; n++) @(posedge clk);
    #1;
    chk("rnd_drained", 32'(q.size()), 32'h0);
    chk("rnd_count",   32'(n_popped - base), 32'd150);

    // Reset while three transactions are in flight and the output is stalled
    rnd_rdy   = 1'b0;
    fixed_rdy = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h0001, 1'b1, 1'b0);
    send(16'h4444, 16'h0004, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("mid_precond_valid", 32'(out_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_sum",   32'(sum),       32'h0);
    chk("mid_rst_cout",  32'(cout),      32'h0);
    chk("mid_rst_ovf",   32'(ovf),       32'h0);
    fixed_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("mid_no_stale", 32'(seen), 32'h0);

    // Pipe still works after the reset
    one("post_rst_add", 16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, STAGES-deep pipelined adder/subtractor. It is the successor to the fixed 8-bit four-stage adder pipeline and replaces it in new datapaths. Each stage adds one CW-bit chunk and passes the carry to the next stage. It adds a valid/ready handshake with backpressure, a subtract mode, signed-overflow detection and asynchronous reset.

Parameters:
WIDTH, 16, operand/result width in bits; WIDTH % STAGES must equal 0 (elaboration error otherwise)
STAGES, 4, number of pipeline stages (>=1); chunk width CW = WIDTH/STAGES

Ports:
clk        input   1      clock, all state on rising edge
rst_n      input   1      asynchronous active-low reset
in_valid   input   1      operand set present
in_ready   output  1      block accepts operands this cycle
ina        input   WIDTH  operand A
inb        input   WIDTH  operand B
cin        input   1      carry-in (add mode only)
sub        input   1      0: A+B+cin; 1: A-B (cin ignored)
out_valid  output  1      result present
out_ready  input   1      downstream accepts result
sum        output  WIDTH  result
cout       output  1      carry-out (sub mode: 1 = no borrow)
ovf        output  1      two's-complement signed overflow

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, sum, cout and ovf go to 0 immediately. in_ready = 1 while rst_n is high after reset. Reset mid-operation discards all in-flight transactions; none emerge later.
- Global stall: adv = out_ready | ~out_valid. in_ready = adv (combinational). All stages shift together only when adv = 1.
- Accept: when in_valid & in_ready, stage 0 captures the operands. When in_valid = 0 and adv = 1, a bubble (valid = 0) enters stage 0.
- Operand preparation at accept:
  - b_eff = sub ? ~inb : inb
  - c0 = sub ? 1 : cin
- Stage k (0..STAGES-1):
  - Computes {carry_k, s[k*CW +: CW]} = a[k*CW +: CW] + b_eff[k*CW +: CW] + carry_(k-1); carry_(-1) = c0.
  - Lower result bits already computed are carried forward.
  - Unused upper operand chunks are delayed alongside.
  - Stage registers hold their values while adv = 0.
- Output:
  - Final stage registers drive sum, cout = carry_(STAGES-1) and out_valid.
  - ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]). The operand MSBs needed for ovf travel through the pipeline with the data.
- Latency: result appears with out_valid = 1 exactly STAGES cycles after the accept edge when no stall occurs. Throughput is 1 per cycle.
- Backpressure: while out_valid & ~out_ready, sum, cout, ovf and out_valid hold stable, in_ready = 0, and no input is accepted.
- Ordering: results emerge strictly in accept order; no loss and no duplication.
- Bubbles: they do not compress while the pipeline is stalled. They are removed only by shifting when out_valid = 0 at the output.
- Wrap-around: sums are modulo 2^WIDTH; overflow is reported only via cout/ovf.
- Sub mode with B = 0: result = A, cout = 1, ovf = 0.
- STAGES = 1 degenerates to a single registered adder with the same handshake.

Test Plan:
- Reset: hold rst_n=0 → out_valid=0, sum=0x0000, cout=0, ovf=0; release → in_ready=1.
- Single add: WIDTH=16, STAGES=4, 0x00FF+0x0001, cin=0, sub=0, out_ready=1 → sum=0x0100, cout=0, ovf=0, out_valid on 4th edge after accept, exactly 1 cycle.
- Full carry ripple and add overflow:
  - 0xFFFF+0x0000, cin=1 → sum=0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 → sum=0x8000, ovf=1.
- Subtract:
  - 0x8000−0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
  - 0x0003−0x0005 → sum=0xFFFE, cout=0, ovf=0.
- Backpressure: 8 back-to-back random transactions with out_ready toggling pseudo-randomly → all 8 results match the reference model in order; outputs stable while stalled; in_ready low during stalls.
- Reset mid-flight: accept 3 transactions, pull rst_n low asynchronously between edges → out_valid drops immediately; after release no stale result ever appears.
